hazard_ctrl: RTL and testbench

//   Pipeline hazard controller for the 5-stage MIPS core; sits beside the Forwarding unit.

---
 rtl/hazard_ctrl_if.sv | 29 ++
 rtl/hazard_ctrl.sv | 89 ++++++++
 tb/tb_hazard_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: decode/EX hazard inputs and stall/flush/mult-div outputs.
// master = pipeline side, slave = hazard controller side.
interface hazard_ctrl_if;
  logic        MemRead_EX;
  logic [4:0]  rt_EX;
  logic [4:0]  rs_ID;
  logic [4:0]  rt_ID;
  logic        uses_rt_ID;
  logic        branch_taken_EX;
  logic        md_start_ID;
  logic        hilo_use_ID;
  logic        PCWrite;
  logic        IFID_Write;
  logic        IFID_Flush;
  logic        IDEX_Flush;
  logic        md_busy;
  logic        md_done;
  logic [15:0] stall_cnt;

  modport master (
    output MemRead_EX, rt_EX, rs_ID, rt_ID, uses_rt_ID, branch_taken_EX, md_start_ID, hilo_use_ID,
    input  PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, md_busy, md_done, stall_cnt
  );

  modport slave (
    input  MemRead_EX, rt_EX, rs_ID, rt_ID, uses_rt_ID, branch_taken_EX, md_start_ID, hilo_use_ID,
    output PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, md_busy, md_done, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use stall, taken-branch flush and HI/LO interlock; stall/flush decisions are same-cycle.
// Mult/div runs MD_LATENCY BUSY cycles plus one DONE strobe; ID holds while a new md/hilo op waits.
module hazard_ctrl #(
  parameter int MD_LATENCY = 32,
  parameter int CNT_W      = 6
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MD_LATENCY - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [15:0]      stall_q;
  logic             load_use;
  logic             md_hold;
  logic             accept;

  always_comb begin
    load_use = hz.MemRead_EX && (hz.rt_EX != 5'd0) &&
               ((hz.rs_ID == hz.rt_EX) || (hz.uses_rt_ID && (hz.rt_ID == hz.rt_EX)));
    md_hold  = (state != IDLE) && (hz.md_start_ID || hz.hilo_use_ID);
    accept   = hz.md_start_ID && !load_use && !hz.branch_taken_EX;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = BUSY;
          cnt_nxt   = CNT_INIT;
        end
      end
      BUSY: begin
        if (cnt == '0) state_nxt = DONE;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Wrong-path ID instruction on a taken branch must not stall, so branch outranks the holds.
  always_comb begin
    hz.PCWrite    = 1'b1;
    hz.IFID_Write = 1'b1;
    hz.IFID_Flush = 1'b0;
    hz.IDEX_Flush = 1'b0;
    if (rst) begin
      hz.PCWrite    = 1'b0;
      hz.IFID_Write = 1'b0;
      hz.IFID_Flush = 1'b1;
      hz.IDEX_Flush = 1'b1;
    end else if (hz.branch_taken_EX) begin
      hz.IFID_Flush = 1'b1;
      hz.IDEX_Flush = 1'b1;
    end else if (load_use || md_hold) begin
      hz.PCWrite    = 1'b0;
      hz.IFID_Write = 1'b0;
      hz.IDEX_Flush = 1'b1;
    end
    hz.md_busy = (state == BUSY) || (state == DONE);
    hz.md_done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst)                                  stall_q <= '0;
    else if (!hz.PCWrite && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
  end

  assign hz.stall_cnt = stall_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a cycle-level reference model and per-cycle comparison.
module tb_hazard_ctrl;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_ctrl_if hz ();

  hazard_ctrl #(.MD_LATENCY(LAT), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: cycles of md_busy still ahead (0 = idle, 1 = done strobe cycle).
  int  busy_left = 0;
  int  stall_m   = 0;
  bit  model_ok  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [3:0] exp_ctrl();
    logic lu, hold;
    lu   = hz.MemRead_EX && hz.rt_EX != 0 &&
           (hz.rs_ID == hz.rt_EX || (hz.uses_rt_ID && hz.rt_ID == hz.rt_EX));
    hold = busy_left != 0 && (hz.md_start_ID || hz.hilo_use_ID);
    if (rst)                  return 4'b0011;
    if (hz.branch_taken_EX)   return 4'b1111;
    if (lu || hold)           return 4'b0001;
    return 4'b1100;
  endfunction

  function automatic bit exp_lu();
    return hz.MemRead_EX && hz.rt_EX != 0 &&
           (hz.rs_ID == hz.rt_EX || (hz.uses_rt_ID && hz.rt_ID == hz.rt_EX));
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      busy_left = 0;
      stall_m   = 0;
      model_ok  = 1;
    end else begin
      logic [3:0] c;
      c = exp_ctrl();
      if (!c[3] && stall_m < 65535) stall_m++;
      if (busy_left > 0) busy_left--;
      else if (hz.md_start_ID && !exp_lu() && !hz.branch_taken_EX) busy_left = LAT + 1;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      logic [3:0] c;
      c = exp_ctrl();
      chk("PCWrite",    hz.PCWrite,    c[3]);
      chk("IFID_Write", hz.IFID_Write, c[2]);
      chk("IFID_Flush", hz.IFID_Flush, c[1]);
      chk("IDEX_Flush", hz.IDEX_Flush, c[0]);
      chk("md_busy",    hz.md_busy,    busy_left > 0);
      chk("md_done",    hz.md_done,    busy_left == 1);
      chk("stall_cnt",  hz.stall_cnt,  stall_m);
    end
  end

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr();
    hz.MemRead_EX = 0; hz.rt_EX = 0; hz.rs_ID = 0; hz.rt_ID = 0;
    hz.uses_rt_ID = 0; hz.branch_taken_EX = 0; hz.md_start_ID = 0; hz.hilo_use_ID = 0;
  endtask

  initial begin
    clr();
    rst = 1;
    cyc(2);
    #3 chk("rst PCWrite", hz.PCWrite, 0);
    chk("rst IFID_Flush", hz.IFID_Flush, 1);
    rst = 0;
    cyc();
    #3 chk("post-rst stall_cnt", hz.stall_cnt, 0);
    chk("post-rst md_busy", hz.md_busy, 0);

    // Load-use on rs, then rt_EX=0, then rt path gated by uses_rt_ID.
    hz.MemRead_EX = 1; hz.rt_EX = 5; hz.rs_ID = 5;
    #3 chk("lu PCWrite", hz.PCWrite, 0);
    chk("lu IDEX_Flush", hz.IDEX_Flush, 1);
    cyc(); clr();
    #3 chk("lu stall_cnt", hz.stall_cnt, 1);
    hz.MemRead_EX = 1;
    #3 chk("r0 PCWrite", hz.PCWrite, 1);
    cyc();
    hz.rt_EX = 7; hz.rt_ID = 7; hz.rs_ID = 1;
    #3 chk("rt no-use PCWrite", hz.PCWrite, 1);
    hz.uses_rt_ID = 1;
    #1 chk("rt use PCWrite", hz.PCWrite, 0);
    cyc(); clr();
    #3 chk("rt stall_cnt", hz.stall_cnt, 2);

    // Branch beats load-use.
    hz.MemRead_EX = 1; hz.rt_EX = 5; hz.rs_ID = 5; hz.branch_taken_EX = 1;
    #3 chk("br PCWrite", hz.PCWrite, 1);
    chk("br IFID_Flush", hz.IFID_Flush, 1);
    chk("br IDEX_Flush", hz.IDEX_Flush, 1);
    cyc(); clr();
    #3 chk("br stall_cnt", hz.stall_cnt, 2);

    // Mult/div with hilo_use held: busy 1..5, done at 5, PC resumes at 6.
    hz.md_start_ID = 1;
    #3 chk("md accept PCWrite", hz.PCWrite, 1);
    cyc();
    hz.md_start_ID = 0; hz.hilo_use_ID = 1;
    for (int k = 1; k <= 6; k++) begin
      #3 chk("md3 busy", hz.md_busy, k <= 5);
      chk("md3 done", hz.md_done, k == 5);
      chk("md3 PCWrite", hz.PCWrite, k == 6);
      cyc();
    end
    clr();
    #3 chk("md3 stall_cnt", hz.stall_cnt, 7);

    // Reset in BUSY cycle 2 abandons the op.
    hz.md_start_ID = 1;
    cyc();
    hz.md_start_ID = 0;
    cyc();
    rst = 1;
    cyc();
    rst = 0;
    for (int k = 0; k < 6; k++) begin
      #3 chk("rst-md done", hz.md_done, 0);
      chk("rst-md busy", hz.md_busy, 0);
      cyc();
    end
    #3 chk("rst-md stall_cnt", hz.stall_cnt, 0);

    // Start blocked by load-use, accepted the following cycle.
    hz.MemRead_EX = 1; hz.rt_EX = 3; hz.rs_ID = 3; hz.md_start_ID = 1;
    cyc();
    #3 chk("lu-md idle", hz.md_busy, 0);
    hz.MemRead_EX = 0;
    cyc();
    hz.md_start_ID = 0;
    #3 chk("lu-md accepted", hz.md_busy, 1);
    cyc();
    hz.branch_taken_EX = 1;
    cyc();
    hz.branch_taken_EX = 0;
    cyc(2);
    #3 chk("br-no-cancel done", hz.md_done, 1);
    cyc(2); clr();

    // Saturation: long load-use run, then repeated hilo/md interlock across 16'hFFFF.
    hz.MemRead_EX = 1; hz.rt_EX = 9; hz.rs_ID = 9;
    cyc(64800);
    clr();
    hz.md_start_ID = 1; hz.hilo_use_ID = 1;
    cyc(1200);
    clr();
    #3 chk("sat stall_cnt", hz.stall_cnt, 16'hFFFF);
    cyc(3);
    #3 chk("sat hold", hz.stall_cnt, 16'hFFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
